// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: word/byte handshake between the SPI slave (master) and the RAM controller (slave)
interface spi_ram_ctrl_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       err;
    modport master (output rx_data, rx_valid, input tx_data, tx_valid, err);
    modport slave  (input rx_data, rx_valid, output tx_data, tx_valid, err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: single-port RAM with a 2-bit command decoder fed by SPI slave words
// Define RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int RD_LAT    = 1
) (
    input logic clk,
    input logic rst,
    spi_ram_ctrl_if.slave bus
);
`ifdef RAM_PARITY_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    state_t state, next_state;
    logic [2:0] cnt, next_cnt;
    logic [W-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic wr_addr_vld, rd_addr_vld, rx_valid_q;
    logic accept, in_range, fault, abort, launch, finish, par_bad;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic [W-1:0] rd_word, wr_word;

    assign accept   = bus.rx_valid & ~rx_valid_q;
    assign cmd      = bus.rx_data[9:8];
    assign payload  = bus.rx_data[7:0];
    assign in_range = int'(payload) < MEM_DEPTH;
    assign rd_word  = mem[rd_addr];
`ifdef RAM_PARITY_EN
    assign wr_word  = {^payload, payload};
    assign par_bad  = ^rd_word;
`else
    assign wr_word  = payload;
    assign par_bad  = 1'b0;
`endif

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end

    always_comb begin
        next_state = finish ? RD_DONE : launch ? RD_WAIT : accept ? IDLE : state;
        next_cnt   = launch ? 3'(RD_LAT - 1) : state == RD_WAIT ? cnt - 3'd1 : cnt;
    end

    // a read finishes at launch when RD_LAT is 1; any accepted command pre-empts a pending read
    always_comb begin
        abort        = accept && state == RD_WAIT;
        fault        = accept && (!cmd[0] ? !in_range : cmd[1] ? !rd_addr_vld : !wr_addr_vld);
        launch       = accept && cmd == 2'b11 && rd_addr_vld;
        finish       = launch ? RD_LAT == 1 : state == RD_WAIT && !accept && cnt == 3'd1;
        bus.tx_valid = state == RD_DONE;
    end

    always_ff @(posedge clk)
        if (rst) begin
            rx_valid_q  <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            bus.tx_data <= '0;
            bus.err     <= 1'b0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            bus.err    <= abort | fault | (finish & par_bad);
            if (finish)
                bus.tx_data <= rd_word[7:0];
            if (accept && in_range && cmd == 2'b00) begin
                wr_addr     <= payload[ADDR_SIZE-1:0];
                wr_addr_vld <= 1'b1;
            end
            if (accept && in_range && cmd == 2'b10) begin
                rd_addr     <= payload[ADDR_SIZE-1:0];
                rd_addr_vld <= 1'b1;
            end
        end

    always_ff @(posedge clk)
        if (!rst && accept && cmd == 2'b01 && wr_addr_vld)
            mem[wr_addr] <= wr_word;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: two controllers (256/lat1 and 128/lat3) on shared random words vs a deadline-based model
module tb_spi_ram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] rx_data = '0;
    logic rx_valid = 1'b0;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl_if bus_a ();
    spi_ram_ctrl_if bus_b ();
    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_valid = rx_valid;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_valid = rx_valid;

    spi_ram_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [7:0] m_mem [2][256];
    bit         m_bad [2][256];
    logic [7:0] m_wa [2], m_ra [2], m_td [2], m_pa [2];
    bit         m_wav [2], m_rav [2], m_tv [2], m_err [2], m_pend [2], m_prev [2];
    int         m_due [2];
    int         m_depth [2] = '{256, 128};
    int         m_lat [2] = '{1, 3};
    int         m_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
    endtask

    // outputs expected after the coming rising edge, given the inputs now applied
    task automatic model_step(input int i);
        logic [1:0] c;
        logic [7:0] p;
        bit acc;
        c = rx_data[9:8];
        p = rx_data[7:0];
        acc = rx_valid && !m_prev[i];
        m_prev[i] = rst ? 1'b0 : rx_valid;
        m_err[i] = 0;
        if (rst) begin
            m_tv[i] = 0; m_td[i] = 0; m_wav[i] = 0; m_rav[i] = 0;
            m_wa[i] = 0; m_ra[i] = 0; m_pend[i] = 0;
            return;
        end
        if (acc) begin
            m_err[i] = m_pend[i];
            m_pend[i] = 0;
            m_tv[i] = 0;
            if (c == 2'd0 || c == 2'd2) begin
                if (int'(p) >= m_depth[i]) m_err[i] = 1;
                else if (c == 2'd0) begin m_wa[i] = p; m_wav[i] = 1; end
                else begin m_ra[i] = p; m_rav[i] = 1; end
            end else if (c == 2'd1) begin
                if (m_wav[i]) begin m_mem[i][m_wa[i]] = p; m_bad[i][m_wa[i]] = 0; end
                else m_err[i] = 1;
            end else if (m_rav[i]) begin
                m_pend[i] = 1;
                m_due[i] = m_cyc + m_lat[i] - 1;
                m_pa[i] = m_ra[i];
            end else m_err[i] = 1;
        end
        if (m_pend[i] && m_cyc == m_due[i]) begin
            m_pend[i] = 0;
            m_tv[i] = 1;
            m_td[i] = m_mem[i][m_pa[i]];
            m_err[i] = m_err[i] | m_bad[i][m_pa[i]];
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
        check("A.tx_valid", 32'(bus_a.tx_valid), 32'(m_tv[0]));
        check("A.tx_data", 32'(bus_a.tx_data), 32'(m_td[0]));
        check("A.err", 32'(bus_a.err), 32'(m_err[0]));
        check("B.tx_valid", 32'(bus_b.tx_valid), 32'(m_tv[1]));
        check("B.tx_data", 32'(bus_b.tx_data), 32'(m_td[1]));
        check("B.err", 32'(bus_b.err), 32'(m_err[1]));
    endtask

    task automatic send(input logic [9:0] w, input int hold, input int gap);
        rx_data = w;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2);
        send(10'h300, 1, 3);
        send(10'h03C, 1, 1);
        send(10'h1A5, 1, 1);
        send(10'h23C, 1, 1);
        send(10'h300, 1, 6);
        send(10'h23C, 1, 4);
        for (int a = 0; a < 256; a++) begin
            send({2'b00, 8'(a)}, 1, 1);
            send({2'b01, 8'($urandom_range(0, 255))}, 1, 1);
        end
        send(10'h220, 1, 1);
        send(10'h300, 1, 1);
        send(10'h210, 1, 4);
        send(10'h300, 1, 5);
        do_reset(2);
        send(10'h080, 1, 1);
        send(10'h155, 1, 3);
        send(10'h007, 1, 1);
        send(10'h13C, 12, 2);
        send(10'h207, 1, 1);
        send(10'h300, 12, 4);
`ifdef RAM_PARITY_EN
        dut_a.mem[5][8] = ~dut_a.mem[5][8];
        dut_b.mem[5][8] = ~dut_b.mem[5][8];
        m_bad[0][5] = 1;
        m_bad[1][5] = 1;
        send(10'h205, 1, 1);
        send(10'h300, 1, 5);
`endif
        for (int n = 0; n < 400; n++) begin
            logic [7:0] p;
            if ($urandom_range(0, 39) == 0) do_reset(1);
            p = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            send({2'($urandom_range(0, 3)), p}, $urandom_range(1, 3), $urandom_range(1, 4));
        end
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
